snake_ctrl: RTL and testbench
=============================

Name: snake_ctrl

Overview:
Game sequencer for the snakegame logic block.
- Owns the run/pause/game-over state machine and generates the one-cycle game_enable move strobe at a speed that rises with score.
- Filters IR remote commands into a legal direction word (no 180° reversals, last legal key per tick wins) and keeps score and high score.
- Sits between the IR decoder and snakegame on the same clock; drives snakegame's direction and game_enable, and consumes its food_eaten and game_over.

Parameters:
TICK_BASE, 12_500_000, clock cycles per move at score 0 (4 Hz at 50 MHz)
TICK_MIN, 2_500_000, fastest allowed move period in cycles
TICK_STEP, 500_000, period reduction per food eaten
OVER_HOLD, 8, move-periods spent in OVER before returning to IDLE

Ports:
game_clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cmd  in  32  IR command code (UP/DOWN/LEFT/RIGHT/OK)
cmd_valid  in  1  one-cycle strobe, cmd valid
food_eaten  in  1  from snakegame, level, held until its next enabled move
game_over  in  1  from snakegame, one-cycle pulse
direction  out  32  direction code to snakegame
game_enable  out  1  one-cycle move strobe to snakegame
score  out  8  food count this game, saturates at 255
hiscore  out  8  best score since reset
state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3 (for display)

Behaviour:
- Interface decided: one clock, game_clk; asynchronous active-low reset, reset_n.
- Reset values: state IDLE, game_enable 0, direction DOWN, pending DOWN, score 0, hiscore 0, period TICK_BASE, tick count 0, hold count 0.
- Command codes: UP 32'h20DF6A95, DOWN 32'h20DFEA15, LEFT 32'h20DF1AE5, RIGHT 32'h20DF9A65, OK 32'h20DF22DD. Any other code is ignored.
- Direction filter:
  - When cmd_valid carries a direction code in IDLE, RUN or PAUSE, pending <= code unless it is the opposite of the currently applied direction.
  - Repeated presses overwrite pending (last legal key wins).
- Tick generation (RUN only):
  - Counter increments each cycle.
  - When it reaches period-1 it wraps to 0 and registers game_enable=1 for exactly one cycle. On that same edge, direction <= pending, so the move uses the new direction.
  - Counter holds its value in PAUSE and clears on entering RUN from IDLE.
- State transitions:
  - IDLE: OK -> RUN.
  - RUN: OK -> PAUSE; game_over pulse -> OVER.
  - PAUSE: OK -> RUN, counter resumes from its held value.
  - OVER: counter keeps running without game_enable. Each wrap increments the hold count; at OVER_HOLD wraps -> IDLE.
  - Leaving OVER: score 0, period TICK_BASE, direction and pending DOWN, counter 0.
- Score:
  - A rising edge of food_eaten (registered previous value) in RUN increments score, saturating at 255.
  - The same edge sets period <= max(period-TICK_STEP, TICK_MIN). Subtract in full counter width and clamp; no underflow.
  - The new period applies from the next counter wrap.
- Hiscore: on entry to OVER, hiscore <= max(hiscore, score).
- Simultaneous events:
  - game_over and a food_eaten edge in the same cycle: game_over wins and the food edge is ignored.
  - OK in the same cycle as a tick wrap: the strobe is still issued, then the FSM moves to PAUSE.
  - cmd_valid in OVER: ignored.
  - game_over outside RUN: ignored.
- Reset mid-operation: every register returns to its reset value asynchronously; game_enable deasserts immediately.
- Widths: counter is $clog2(TICK_BASE) bits; hold count is $clog2(OVER_HOLD+1) bits.

Decomposition:
- Package snake_pkg:
  - IR command code constants.
  - State enum (2-bit).
  - Function opposite(code) returning the reverse direction code.
- One sub-module, snake_tick_gen: programmable period divider with run/clear inputs, period input and a one-cycle wrap output. Instantiated once and shared by RUN (move strobe) and OVER (hold timing).

Test Plan:
Use TICK_BASE=10, TICK_MIN=4, TICK_STEP=2, OVER_HOLD=3 for all scenarios.
- Reset then OK -> state=1; first game_enable 10 cycles after entry, then every 10 cycles, each exactly 1 cycle wide; direction=DOWN.
- Applied direction RIGHT; press UP then LEFT within one tick -> next strobe has direction=UP. Press LEFT alone while RIGHT is applied -> ignored, direction stays RIGHT.
- Hold food_eaten high for 1..10 cycles, four separate times -> score=4; periods go 10->8->6->4->4 (clamped); strobe spacing matches from the next wrap.
- OK in RUN -> no strobes for 50 cycles, state=2; OK again -> strobe after the remaining count, not a full period.
- score=5, game_over pulse -> state=3 and hiscore=5; no game_enable for 3 periods, then state=0 with score=0 and direction=DOWN. Next game with score=2 ends -> hiscore stays 5.
- Assert reset_n low mid-RUN while game_enable=1 -> outputs return to reset values without waiting for a clock edge. game_over and a food_eaten rise in the same cycle -> score unchanged, state=3.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: IR command codes,
// FSM state encoding and direction helpers.
package snake_pkg;

    localparam logic [31:0] CMD_UP    = 32'h20DF6A95;
    localparam logic [31:0] CMD_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] CMD_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] CMD_RIGHT = 32'h20DF9A65;
    localparam logic [31:0] CMD_OK    = 32'h20DF22DD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    function automatic logic [31:0] opposite(input logic [31:0] code);
        logic [31:0] rev;
        case (code)
            CMD_UP:    rev = CMD_DOWN;
            CMD_DOWN:  rev = CMD_UP;
            CMD_LEFT:  rev = CMD_RIGHT;
            CMD_RIGHT: rev = CMD_LEFT;
            default:   rev = 32'h0;
        endcase
        return rev;
    endfunction

    function automatic logic is_dir(input logic [31:0] code);
        return (code == CMD_UP) || (code == CMD_DOWN) ||
               (code == CMD_LEFT) || (code == CMD_RIGHT);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Programmable period divider. The period is latched at each wrap (or while
// cleared), so a period change takes effect from the next wrap onward.
module snake_tick_gen #(
    parameter int            CW         = 4,
    parameter int            PW         = 4,
    parameter logic [PW-1:0] PERIOD_RST = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          run_i,
    input  logic          clear_i,
    input  logic [PW-1:0] period_i,
    output logic          wrap_o
);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] active_q, active_d;
    logic          hit;

    assign hit    = (PW'(count_q) == (active_q - PW'(1)));
    assign wrap_o = run_i && !clear_i && hit;

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (clear_i) begin
            count_d  = '0;
            active_d = period_i;
        end else if (run_i) begin
            if (hit) begin
                count_d  = '0;
                active_d = period_i;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            active_q <= PERIOD_RST;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Game sequencer: run/pause/over FSM, score-dependent move strobe,
// IR direction filtering and score/high-score keeping.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_BASE = 12_500_000,
    parameter int TICK_MIN  = 2_500_000,
    parameter int TICK_STEP = 500_000,
    parameter int OVER_HOLD = 8
) (
    input  logic        game_clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] cmd_i,
    input  logic        cmd_valid_i,
    input  logic        food_eaten_i,
    input  logic        game_over_i,
    output logic [31:0] direction_o,
    output logic        game_enable_o,
    output logic [7:0]  score_o,
    output logic [7:0]  hiscore_o,
    output logic [1:0]  state_o
);

    localparam int CW = $clog2(TICK_BASE);
    localparam int PW = $clog2(TICK_BASE + 1);
    localparam int HW = $clog2(OVER_HOLD + 1);

    localparam logic [PW-1:0] PERIOD_BASE = PW'(TICK_BASE);
    localparam logic [PW-1:0] PERIOD_MIN  = PW'(TICK_MIN);
    localparam logic [PW-1:0] PERIOD_STEP = PW'(TICK_STEP);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(OVER_HOLD - 1);

    state_e        state_q, state_d;
    logic [31:0]   dir_q, dir_d;
    logic [31:0]   pend_q, pend_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    hi_q, hi_d;
    logic [PW-1:0] period_q, period_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          en_q, en_d;
    logic          food_prev_q;

    logic ok_cmd, dir_cmd, food_rise;
    logic tick_run, tick_clear, wrap;

    assign ok_cmd     = cmd_valid_i && (cmd_i == CMD_OK);
    assign dir_cmd    = cmd_valid_i && is_dir(cmd_i);
    assign food_rise  = food_eaten_i && !food_prev_q;
    assign tick_run   = (state_q == ST_RUN) || (state_q == ST_OVER);
    assign tick_clear = (state_q == ST_IDLE);

    snake_tick_gen #(
        .CW         (CW),
        .PW         (PW),
        .PERIOD_RST (PERIOD_BASE)
    ) u_tick (
        .clk_i    (game_clk_i),
        .rst_ni   (reset_n_i),
        .run_i    (tick_run),
        .clear_i  (tick_clear),
        .period_i (period_q),
        .wrap_o   (wrap)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        score_d  = score_q;
        hi_d     = hi_q;
        period_d = period_q;
        hold_d   = hold_q;
        en_d     = 1'b0;

        // A reversal is judged against the direction already applied, not the pending one.
        if (state_q != ST_OVER && dir_cmd && cmd_i != opposite(dir_q)) begin
            pend_d = cmd_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (ok_cmd) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wrap) begin
                    en_d  = 1'b1;
                    dir_d = pend_q;
                end
                if (game_over_i) begin
                    state_d = ST_OVER;
                    hold_d  = '0;
                    if (score_q > hi_q) hi_d = score_q;
                end else begin
                    if (ok_cmd) state_d = ST_PAUSE;
                    if (food_rise) begin
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        if (32'(period_q) >= 32'(TICK_MIN + TICK_STEP)) begin
                            period_d = period_q - PERIOD_STEP;
                        end else begin
                            period_d = PERIOD_MIN;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (ok_cmd) state_d = ST_RUN;
            end
            ST_OVER: begin
                if (wrap) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d  = ST_IDLE;
                        hold_d   = '0;
                        score_d  = 8'd0;
                        period_d = PERIOD_BASE;
                        dir_d    = CMD_DOWN;
                        pend_d   = CMD_DOWN;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge game_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            dir_q       <= CMD_DOWN;
            pend_q      <= CMD_DOWN;
            score_q     <= 8'd0;
            hi_q        <= 8'd0;
            period_q    <= PERIOD_BASE;
            hold_q      <= '0;
            en_q        <= 1'b0;
            food_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            score_q     <= score_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            hold_q      <= hold_d;
            en_q        <= en_d;
            food_prev_q <= food_eaten_i;
        end
    end

    assign direction_o   = dir_q;
    assign game_enable_o = en_q;
    assign score_o       = score_q;
    assign hiscore_o     = hi_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: a scripted vector table, hand-written corner-case
// sequences, and randomized stimulus checked against a countdown-style model.
module tb_snake_ctrl;
    import snake_pkg::*;

    localparam int TB = 10;
    localparam int TM = 4;
    localparam int TS = 2;
    localparam int OH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd = 32'h0;
    logic        cmd_valid = 1'b0;
    logic        food = 1'b0;
    logic        gover = 1'b0;
    logic [31:0] direction;
    logic        game_enable;
    logic [7:0]  score;
    logic [7:0]  hiscore;
    logic [1:0]  state;

    always #5 clk = ~clk;

    snake_ctrl #(
        .TICK_BASE (TB),
        .TICK_MIN  (TM),
        .TICK_STEP (TS),
        .OVER_HOLD (OH)
    ) dut (
        .game_clk_i    (clk),
        .reset_n_i     (rst_n),
        .cmd_i         (cmd),
        .cmd_valid_i   (cmd_valid),
        .food_eaten_i  (food),
        .game_over_i   (gover),
        .direction_o   (direction),
        .game_enable_o (game_enable),
        .score_o       (score),
        .hiscore_o     (hiscore),
        .state_o       (state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time to the next move is a countdown reloaded from the
    // period in force, directions are indexed so that opposites differ in bit 0.
    logic [31:0] dirs [4] = '{CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};
    int          m_state, m_left, m_per, m_hold, m_score, m_hi;
    logic [31:0] m_dir, m_pend;
    bit          m_en, m_food_prev;

    function automatic int dir_index(input logic [31:0] c);
        for (int i = 0; i < 4; i++) if (dirs[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_left = TB; m_per = TB; m_hold = 0;
        m_score = 0; m_hi = 0; m_dir = CMD_DOWN; m_pend = CMD_DOWN;
        m_en = 1'b0; m_food_prev = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] c, input bit v, input bit f, input bit g);
        bit ok, rise, wrap;
        int di, ai, ns, nleft, nper, nhold, nsc, nhi;
        logic [31:0] ndir, npend;
        bit nen;
        ok = v && (c == CMD_OK);
        rise = f && !m_food_prev;
        di = v ? dir_index(c) : -1;
        ai = dir_index(m_dir);
        ns = m_state; nleft = m_left; nper = m_per; nhold = m_hold;
        nsc = m_score; nhi = m_hi; ndir = m_dir; npend = m_pend;
        nen = 1'b0; wrap = 1'b0;
        if (m_state == 0) begin
            nleft = m_per;
        end else if (m_state == 1 || m_state == 3) begin
            nleft = m_left - 1;
            if (nleft == 0) begin
                wrap = 1'b1;
                nleft = m_per;
            end
        end
        if (m_state != 3 && di >= 0 && di != (ai ^ 1)) npend = c;
        case (m_state)
            0: if (ok) ns = 1;
            1: begin
                if (wrap) begin nen = 1'b1; ndir = m_pend; end
                if (g) begin
                    ns = 3; nhold = 0;
                    nhi = (m_score > m_hi) ? m_score : m_hi;
                end else begin
                    if (ok) ns = 2;
                    if (rise) begin
                        nsc = (m_score < 255) ? m_score + 1 : 255;
                        nper = (m_per - TS < TM) ? TM : m_per - TS;
                    end
                end
            end
            2: if (ok) ns = 1;
            default: begin
                if (wrap) begin
                    nhold = m_hold + 1;
                    if (nhold == OH) begin
                        ns = 0; nhold = 0; nsc = 0; nper = TB;
                        ndir = CMD_DOWN; npend = CMD_DOWN;
                    end
                end
            end
        endcase
        m_state = ns; m_left = nleft; m_per = nper; m_hold = nhold;
        m_score = nsc; m_hi = nhi; m_dir = ndir; m_pend = npend;
        m_en = nen; m_food_prev = f;
    endtask

    task automatic check_all(input string tag, input int es, input bit een,
                             input logic [31:0] edir, input int esc, input int ehi);
        n_cmp++;
        if (state !== 2'(es) || game_enable !== een || direction !== edir ||
            score !== 8'(esc) || hiscore !== 8'(ehi)) begin
            n_bad++;
            $display("FAIL %s: got state=%0d en=%0b dir=%h score=%0d hi=%0d, want state=%0d en=%0b dir=%h score=%0d hi=%0d",
                     tag, state, game_enable, direction, score, hiscore, es, een, edir, esc, ehi);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample at the falling edge.
    task automatic step_cycle(input logic [31:0] c, input bit v, input bit f, input bit g);
        cmd = c; cmd_valid = v; food = f; gover = g;
        @(posedge clk);
        model_step(c, v, f, g);
        @(negedge clk);
    endtask

    task automatic wait_en(output int n);
        n = 0;
        do begin
            step_cycle(32'h0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (game_enable !== 1'b1 && n < 40);
        if (game_enable !== 1'b1) n = -1;
    endtask

    task automatic wait_idle(output int n_en, output int cyc);
        n_en = 0; cyc = 0;
        while (state !== 2'd0 && cyc < 80) begin
            step_cycle(32'h0, 1'b0, 1'b0, 1'b0);
            cyc++;
            if (game_enable === 1'b1) n_en++;
        end
        if (state !== 2'd0) cyc = -1;
    endtask

    typedef struct {
        logic [31:0] cmd;
        bit          valid;
        bit          food;
        bit          gov;
        int          idle;
        int          st;
        bit          en;
        logic [31:0] dir;
        int          sc;
        int          hi;
    } vec_t;

    vec_t tbl [24];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cur, nxt, en_cnt, cyc;
        bit f_lvl;

        tbl[0]  = '{CMD_OK,    1'b1, 1'b0, 1'b0, 0,  1, 1'b0, CMD_DOWN,  0, 0};
        tbl[1]  = '{32'h0,     1'b0, 1'b0, 1'b0, 8,  1, 1'b0, CMD_DOWN,  0, 0};
        tbl[2]  = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b1, CMD_DOWN,  0, 0};
        tbl[3]  = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b0, CMD_DOWN,  0, 0};
        tbl[4]  = '{CMD_RIGHT, 1'b1, 1'b0, 1'b0, 7,  1, 1'b0, CMD_DOWN,  0, 0};
        tbl[5]  = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b1, CMD_RIGHT, 0, 0};
        tbl[6]  = '{CMD_LEFT,  1'b1, 1'b0, 1'b0, 8,  1, 1'b0, CMD_RIGHT, 0, 0};
        tbl[7]  = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b1, CMD_RIGHT, 0, 0};
        tbl[8]  = '{CMD_UP,    1'b1, 1'b0, 1'b0, 0,  1, 1'b0, CMD_RIGHT, 0, 0};
        tbl[9]  = '{CMD_LEFT,  1'b1, 1'b0, 1'b0, 7,  1, 1'b0, CMD_RIGHT, 0, 0};
        tbl[10] = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b1, CMD_UP,    0, 0};
        tbl[11] = '{32'h0,     1'b0, 1'b1, 1'b0, 0,  1, 1'b0, CMD_UP,    1, 0};
        tbl[12] = '{32'h0,     1'b0, 1'b1, 1'b0, 0,  1, 1'b0, CMD_UP,    1, 0};
        tbl[13] = '{32'h0,     1'b0, 1'b0, 1'b0, 7,  1, 1'b1, CMD_UP,    1, 0};
        tbl[14] = '{32'h0,     1'b0, 1'b0, 1'b0, 6,  1, 1'b0, CMD_UP,    1, 0};
        tbl[15] = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b1, CMD_UP,    1, 0};
        tbl[16] = '{CMD_OK,    1'b1, 1'b0, 1'b0, 0,  2, 1'b0, CMD_UP,    1, 0};
        tbl[17] = '{32'h0,     1'b0, 1'b0, 1'b0, 19, 2, 1'b0, CMD_UP,    1, 0};
        tbl[18] = '{CMD_OK,    1'b1, 1'b0, 1'b0, 0,  1, 1'b0, CMD_UP,    1, 0};
        tbl[19] = '{32'h0,     1'b0, 1'b0, 1'b0, 5,  1, 1'b0, CMD_UP,    1, 0};
        tbl[20] = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  1, 1'b1, CMD_UP,    1, 0};
        tbl[21] = '{32'h0,     1'b0, 1'b0, 1'b1, 0,  3, 1'b0, CMD_UP,    1, 1};
        tbl[22] = '{32'h0,     1'b0, 1'b0, 1'b0, 21, 3, 1'b0, CMD_UP,    1, 1};
        tbl[23] = '{32'h0,     1'b0, 1'b0, 1'b0, 0,  0, 1'b0, CMD_DOWN,  0, 1};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0, 1'b0, CMD_DOWN, 0, 0);
        model_reset();
        rst_n = 1'b1;

        // Scripted vectors: one input cycle, some idle cycles, then a check
        for (int i = 0; i < 24; i++) begin
            step_cycle(tbl[i].cmd, tbl[i].valid, tbl[i].food, tbl[i].gov);
            for (int k = 0; k < tbl[i].idle; k++) step_cycle(32'h0, 1'b0, 1'b0, 1'b0);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, tbl[i].dir, tbl[i].sc, tbl[i].hi);
            $display("vec%0d: state=%0d en=%0b dir=%h score=%0d hi=%0d", i, state, game_enable, direction, score, hiscore);
        end

        // Period shrink per food, clamped at the minimum; new period from the next wrap
        step_cycle(CMD_OK, 1'b1, 1'b0, 1'b0);
        wait_en(n);
        chk_int("first_strobe", n, TB);
        cur = TB;
        for (int k = 0; k < 5; k++) begin
            nxt = (cur - TS < TM) ? TM : cur - TS;
            step_cycle(32'h0, 1'b0, 1'b1, 1'b0);
            wait_en(n);
            chk_int($sformatf("old_period%0d", k), n + 1, cur);
            wait_en(n);
            chk_int($sformatf("new_period%0d", k), n, nxt);
            $display("food%0d: period %0d -> %0d, score=%0d", k, cur, nxt, score);
            cur = nxt;
        end
        chk_int("score5", int'(score), 5);

        // Game over with score 5, hold then back to IDLE
        step_cycle(32'h0, 1'b0, 1'b0, 1'b1);
        check_all("over_entry", 3, 1'b0, direction, 5, 5);
        wait_idle(en_cnt, cyc);
        chk_int("over_no_strobe", en_cnt, 0);
        chk_int("over_exit_bounded", int'(cyc > 0), 1);
        check_all("over_exit", 0, 1'b0, CMD_DOWN, 0, 5);
        $display("over: exited after %0d cycles, strobes=%0d", cyc, en_cnt);

        // Second game ends with score 2: hiscore keeps 5
        step_cycle(CMD_OK, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step_cycle(32'h0, 1'b0, 1'b1, 1'b0);
            step_cycle(32'h0, 1'b0, 1'b0, 1'b0);
        end
        step_cycle(32'h0, 1'b0, 1'b0, 1'b1);
        chk_int("game2_state", int'(state), 3);
        chk_int("game2_score", int'(score), 2);
        chk_int("game2_hi", int'(hiscore), 5);
        wait_idle(en_cnt, cyc);
        chk_int("game2_idle", int'(cyc > 0), 1);

        // game_over and a food rise together: food ignored
        step_cycle(CMD_OK, 1'b1, 1'b0, 1'b0);
        step_cycle(32'h0, 1'b0, 1'b1, 1'b0);
        step_cycle(32'h0, 1'b0, 1'b0, 1'b0);
        step_cycle(32'h0, 1'b0, 1'b1, 1'b1);
        chk_int("simul_state", int'(state), 3);
        chk_int("simul_score", int'(score), 1);
        $display("simul: state=%0d score=%0d hi=%0d", state, score, hiscore);
        wait_idle(en_cnt, cyc);
        chk_int("simul_idle", int'(cyc > 0), 1);

        // Asynchronous reset while the move strobe is high
        step_cycle(CMD_OK, 1'b1, 1'b0, 1'b0);
        wait_en(n);
        chk_int("pre_reset_strobe", n, TB);
        cmd_valid = 1'b0; food = 1'b0; gover = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 0, 1'b0, CMD_DOWN, 0, 0);
        $display("async reset: state=%0d en=%0b hi=%0d", state, game_enable, hiscore);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized phase against the model
        f_lvl = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            int r;
            logic [31:0] c;
            bit v, g;
            r = $urandom_range(0, 99);
            v = 1'b1;
            if (r < 8)       c = CMD_OK;
            else if (r < 40) c = dirs[$urandom_range(0, 3)];
            else if (r < 45) c = $urandom;
            else begin c = $urandom; v = 1'b0; end
            if ($urandom_range(0, 4) == 0) f_lvl = ~f_lvl;
            g = ($urandom_range(0, 149) == 0);
            step_cycle(c, v, f_lvl, g);
            check_all($sformatf("rand%0d", t), m_state, m_en, m_dir, m_score, m_hi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
